// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receive path: frame-controller state
//   encoding and the bit_cnt landmarks used to index the frame.
package uart_rx_pkg;

    // Frame controller states. Encodings 5..7 are unused and fall back to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // bit_cnt value while the start bit is on the line.
    localparam logic [3:0] BIT_START = 4'd0;

    // bit_cnt value of the bit that follows the last data bit
    // (parity when enabled, otherwise stop).
    function automatic logic [3:0] bit_par(input int unsigned data_w);
        return 4'(data_w + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if
//   Bundle between the UART frame controller and the RX datapath
//   (sampler, deserializer, start/parity/stop checkers).
//   master : frame controller - drives counters, enables, strobes, result pulses;
//            receives checker flags.
//   slave  : datapath side - the reverse directions.
//   Signals:
//     edge_cnt     oversampling edge within the current bit
//     bit_cnt      bit position within the frame
//     dat_samp_en  majority sampler enable
//     deser_en     deserializer write strobe
//     strt_chk_en / par_chk_en / stp_chk_en   checker strobes
//     data_valid / frame_error                frame result pulses
//     strt_glitch / par_err / stp_err         checker flags
interface uart_rx_fsm_if #(
    parameter int PRESCALE_W = 6
);
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  dat_samp_en;
    logic                  deser_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  data_valid;
    logic                  frame_error;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output edge_cnt, bit_cnt, dat_samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, frame_error,
        input  strt_glitch, par_err, stp_err
    );

    modport slave (
        input  edge_cnt, bit_cnt, dat_samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, frame_error,
        output strt_glitch, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// edge_bit_counter
//   Oversampling edge counter and frame bit counter for the UART receiver.
//   Ports:
//     CLK       oversampling clock
//     RST       async active-low reset
//     en        count enable (frame in progress)
//     clr       synchronous clear of both counters, wins over en
//     prescale  oversampling ratio for the current frame
//     edge_cnt  0..prescale-1, wraps to 0
//     bit_cnt   increments on each edge_cnt wrap
module edge_bit_counter #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt
);

    logic last_edge;

    assign last_edge = (edge_cnt == prescale - 1'b1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            if (last_edge) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
//   Frame controller for the UART receiver. Tracks oversampling edges and bit
//   positions and sequences the sampler, deserializer, start/parity/stop
//   checkers and the data_valid / frame_error pulses.
//   Ports:
//     CLK       oversampling clock (Prescale x baud)
//     RST       async active-low reset
//     RX_IN     serial line, idle high
//     PAR_EN    frame carries a parity bit (latched at frame start)
//     Prescale  oversampling ratio 8/16/32 (latched at frame start)
//     bus       master side of uart_rx_fsm_if (counters, strobes, checker flags)
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    uart_rx_fsm_if.master         bus
);

    localparam logic [3:0] BIT_LAST_DATA = 4'(DATA_W);

    rx_state_t             state_q;
    rx_state_t             state_d;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  err_q;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic [PRESCALE_W-1:0] strobe_edge;
    logic                  at_strobe;
    logic                  last_edge;
    logic                  frame_start;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  frame_err;

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_counter (
        .CLK      (CLK),
        .RST      (RST),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    // The sampler votes on edges H-1..H+1, so its result is usable at H+2.
    assign strobe_edge = (prescale_q >> 1) + PRESCALE_W'(2);
    assign at_strobe   = (edge_cnt == strobe_edge);
    assign last_edge   = (edge_cnt == prescale_q - 1'b1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!RX_IN)   state_d = START;
            START:  if (last_edge) state_d = bus.strt_glitch ? IDLE : DATA;
            DATA:   if (last_edge && bit_cnt == BIT_LAST_DATA)
                        state_d = par_en_q ? PARITY : STOP;
            PARITY: if (last_edge) state_d = STOP;
            STOP:   if (last_edge) state_d = RX_IN ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // A new frame begins either from IDLE or straight out of STOP
    // (back-to-back); both restart the counters and relatch the config.
    assign frame_start = (state_d == START) && (state_q != START);
    assign cnt_clr     = (state_d == IDLE) || frame_start;
    assign cnt_en      = (state_q != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            prescale_q <= PRESCALE_W'(8);
            par_en_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (frame_start) begin
                prescale_q <= Prescale;
                par_en_q   <= PAR_EN;
                err_q      <= 1'b0;
            end else if (state_q == PARITY && last_edge) begin
                err_q <= bus.par_err;
            end
        end
    end

    // Outputs are decoded from state and counters only; RX_IN never reaches them.
    assign frame_err = err_q | bus.stp_err;

    always_comb begin
        bus.edge_cnt    = edge_cnt;
        bus.bit_cnt     = bit_cnt;
        bus.dat_samp_en = (state_q != IDLE);
        bus.strt_chk_en = (state_q == START)  && at_strobe;
        bus.deser_en    = (state_q == DATA)   && at_strobe &&
                          (bit_cnt != BIT_START) && (bit_cnt < bit_par(DATA_W));
        bus.par_chk_en  = (state_q == PARITY) && at_strobe;
        bus.stp_chk_en  = (state_q == STOP)   && at_strobe;
        bus.data_valid  = (state_q == STOP)   && last_edge && !frame_err;
        bus.frame_error = (state_q == STOP)   && last_edge &&  frame_err;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm
//   Directed bench for uart_rx_fsm. Drives serial frames bit by bit, plays the
//   checker flags directly, and tallies strobes/pulses seen each cycle.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;

    uart_rx_fsm_if #(.PRESCALE_W(6)) rx_if ();

    uart_rx_fsm #(
        .DATA_W     (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .PAR_EN   (PAR_EN),
        .Prescale (Prescale),
        .bus      (rx_if)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // per-frame tallies
    int         n_deser, n_strt, n_par, n_stp, n_dv, n_fe, n_both, gap_idle;
    int         deser_bit_sum, deser_edge, strt_edge;
    int         dv_edge, dv_bit, fe_edge, fe_bit;
    logic [7:0] cap;
    logic [7:0] dv_data [2];
    int         frame_cyc, sw_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0; n_dv = 0; n_fe = 0;
        n_both = 0; gap_idle = 0; deser_bit_sum = 0; deser_edge = -1; strt_edge = -1;
        dv_edge = -1; dv_bit = -1; fe_edge = -1; fe_bit = -1;
        cap = 8'h00; dv_data[0] = 8'h00; dv_data[1] = 8'h00;
        frame_cyc = 0; sw_cyc = 0;
    endtask

    // Drive one line cycle, sample outputs on the falling edge, return just after the rising edge.
    task automatic step(input logic rx);
        RX_IN = rx;
        frame_cyc++;
        if (sw_cyc != 0 && frame_cyc == sw_cyc) Prescale = 6'd16;
        @(negedge CLK);
        if (n_dv == 1 && !rx_if.dat_samp_en) gap_idle++;
        if (rx_if.deser_en) begin
            n_deser++;
            deser_bit_sum += int'(rx_if.bit_cnt);
            deser_edge = int'(rx_if.edge_cnt);
            if (rx_if.bit_cnt >= 4'd1 && rx_if.bit_cnt <= 4'd8) cap[rx_if.bit_cnt - 4'd1] = RX_IN;
        end
        if (rx_if.strt_chk_en) begin n_strt++; strt_edge = int'(rx_if.edge_cnt); end
        if (rx_if.par_chk_en) n_par++;
        if (rx_if.stp_chk_en) n_stp++;
        if (rx_if.data_valid && rx_if.frame_error) n_both++;
        if (rx_if.data_valid) begin
            if (n_dv < 2) dv_data[n_dv] = cap;
            dv_edge = int'(rx_if.edge_cnt);
            dv_bit  = int'(rx_if.bit_cnt);
            n_dv++;
        end
        if (rx_if.frame_error) begin
            n_fe++;
            fe_edge = int'(rx_if.edge_cnt);
            fe_bit  = int'(rx_if.bit_cnt);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par_bit,
                              input logic stop_bit, input int bl);
        repeat (bl) step(1'b0);
        for (int i = 0; i < 8; i++) repeat (bl) step(d[i]);
        if (with_par) repeat (bl) step(par_bit);
        repeat (bl) step(stop_bit);
    endtask

    initial begin
        logic       hit;
        logic [7:0] rst_frame;
        int         bi;

        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        rx_if.strt_glitch = 1'b0; rx_if.par_err = 1'b0; rx_if.stp_err = 1'b0;
        clr_mon();

        #2;
        check("reset_outs",
              {rx_if.dat_samp_en, rx_if.deser_en, rx_if.strt_chk_en, rx_if.par_chk_en,
               rx_if.stp_chk_en, rx_if.data_valid, rx_if.frame_error, rx_if.edge_cnt, rx_if.bit_cnt},
              32'h0);
        #10 RST = 1'b1;
        @(posedge CLK); #1;
        idle(3);

        // 1: Prescale 8, no parity, 0xA5
        clr_mon();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
        idle(4);
        check("t1_deser_cnt", n_deser, 8);
        check("t1_deser_bits", deser_bit_sum, 36);
        check("t1_deser_edge", deser_edge, 6);
        check("t1_strt_edge", strt_edge, 6);
        check("t1_data", dv_data[0], 8'hA5);
        check("t1_dv_cnt", n_dv, 1);
        check("t1_dv_pos", {dv_bit[7:0], dv_edge[7:0]}, {8'd9, 8'd7});
        check("t1_fe_cnt", n_fe, 0);
        check("t1_stp_cnt", n_stp, 1);
        check("t1_idle", rx_if.dat_samp_en, 1'b0);

        // 2: parity enabled, 0x3C with wrong (odd) parity bit
        clr_mon();
        PAR_EN = 1'b1; rx_if.par_err = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 8);
        idle(4);
        PAR_EN = 1'b0; rx_if.par_err = 1'b0;
        check("t2_par_cnt", n_par, 1);
        check("t2_deser_cnt", n_deser, 8);
        check("t2_fe_cnt", n_fe, 1);
        check("t2_fe_pos", {fe_bit[7:0], fe_edge[7:0]}, {8'd10, 8'd7});
        check("t2_dv_cnt", n_dv, 0);
        check("t2_idle", rx_if.dat_samp_en, 1'b0);

        // 3: 2-cycle glitch on the line, start checker reports it
        clr_mon();
        rx_if.strt_glitch = 1'b1;
        step(1'b0); step(1'b0);
        idle(14);
        rx_if.strt_glitch = 1'b0;
        check("t3_strt_cnt", n_strt, 1);
        check("t3_deser_cnt", n_deser, 0);
        check("t3_pulses", {n_dv[7:0], n_fe[7:0]}, 16'h0);
        check("t3_idle", {rx_if.dat_samp_en, rx_if.bit_cnt}, 5'h0);

        // 4: Prescale 16, stop bit low
        clr_mon();
        Prescale = 6'd16; rx_if.stp_err = 1'b1;
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 16);
        idle(4);
        rx_if.stp_err = 1'b0;
        check("t4_deser_edge", deser_edge, 10);
        check("t4_data", cap, 8'h96);
        check("t4_fe_cnt", n_fe, 1);
        check("t4_fe_pos", {fe_bit[7:0], fe_edge[7:0]}, {8'd9, 8'd15});
        check("t4_dv_cnt", n_dv, 0);

        // 5: Prescale 32, back-to-back 0x55 then 0xFF
        clr_mon();
        Prescale = 6'd32;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 32);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 32);
        idle(4);
        check("t5_dv_cnt", n_dv, 2);
        check("t5_data0", dv_data[0], 8'h55);
        check("t5_data1", dv_data[1], 8'hFF);
        check("t5_gap_idle", gap_idle, 0);
        check("t5_strt_cnt", n_strt, 2);
        check("t5_deser_edge", deser_edge, 18);
        check("t5_both", n_both, 0);

        // 6a: Prescale raised to 16 mid-frame; frame keeps 8-cycle bits
        clr_mon();
        Prescale = 6'd8;
        sw_cyc = 20;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8);
        idle(4);
        check("t6_presc_dv", n_dv, 1);
        check("t6_presc_data", dv_data[0], 8'hC3);
        check("t6_presc_edge", dv_edge, 7);
        check("t6_presc_fe", n_fe, 0);
        Prescale = 6'd8;
        idle(40);

        // 6b: reset during DATA at bit_cnt 4
        clr_mon();
        rst_frame = 8'hA5;
        hit = 1'b0;
        for (int c = 0; c < 80 && !hit; c++) begin
            bi = c / 8;
            if (bi == 0) step(1'b0);
            else if (bi <= 8) step(rst_frame[bi-1]);
            else step(1'b1);
            if (rx_if.bit_cnt == 4'd4 && rx_if.dat_samp_en) hit = 1'b1;
        end
        check("t6_reach_bit4", hit, 1'b1);
        RST = 1'b0;
        #1;
        check("t6_rst_outs",
              {rx_if.dat_samp_en, rx_if.deser_en, rx_if.strt_chk_en, rx_if.par_chk_en,
               rx_if.stp_chk_en, rx_if.data_valid, rx_if.frame_error, rx_if.edge_cnt, rx_if.bit_cnt},
              32'h0);
        RX_IN = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b1;
        clr_mon();
        idle(20);
        check("t6_post_idle", {rx_if.dat_samp_en, rx_if.edge_cnt}, 7'h0);
        check("t6_post_pulses", {n_dv[7:0], n_fe[7:0]}, 16'h0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8);
        idle(4);
        check("t6_recover", {n_dv[7:0], dv_data[0]}, {8'd1, 8'h5A});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
